// File: rtl/bus_arbiter.sv
// Two-master, one-slave arbiter for the sel/read/write_mask/ready memory bus.
// The grant is held until the slave completes; the watchdog forces completion of hung slaves.
module bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_address_in,
  input  logic                    m0_sel_in,
  input  logic                    m0_read_in,
  input  logic [DATA_WIDTH/8-1:0] m0_write_mask_in,
  input  logic [DATA_WIDTH-1:0]   m0_write_value_in,
  output logic [DATA_WIDTH-1:0]   m0_read_value_out,
  output logic                    m0_ready_out,
  input  logic [ADDR_WIDTH-1:0]   m1_address_in,
  input  logic                    m1_sel_in,
  input  logic                    m1_read_in,
  input  logic [DATA_WIDTH/8-1:0] m1_write_mask_in,
  input  logic [DATA_WIDTH-1:0]   m1_write_value_in,
  output logic [DATA_WIDTH-1:0]   m1_read_value_out,
  output logic                    m1_ready_out,
  output logic [ADDR_WIDTH-1:0]   s_address_out,
  output logic                    s_sel_out,
  output logic                    s_read_out,
  output logic [DATA_WIDTH/8-1:0] s_write_mask_out,
  output logic [DATA_WIDTH-1:0]   s_write_value_out,
  input  logic [DATA_WIDTH-1:0]   s_read_value_in,
  input  logic                    s_ready_in,
  output logic                    timeout_out
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  owner_t            owner_reg, owner_next;
  logic              last_reg, last_next;   // 1: m1 was granted last
  logic [WDOG_W-1:0] wdog_reg, wdog_next;

  logic grant0, grant1, wdog_expired, timeout_hit, done;

  // Gating with reset keeps every output low for as long as reset is held.
  assign grant0      = (owner_reg == OWN_M0) && !reset;
  assign grant1      = (owner_reg == OWN_M1) && !reset;
  assign timeout_hit = (grant0 || grant1) && wdog_expired && !s_ready_in;
  assign done        = s_ready_in || wdog_expired;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      assign wdog_expired = (wdog_reg == WDOG_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wdog
      assign wdog_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg <= OWN_NONE;
      last_reg  <= 1'b1;
      wdog_reg  <= '0;
    end else begin
      owner_reg <= owner_next;
      last_reg  <= last_next;
      wdog_reg  <= wdog_next;
    end
  end

  always_comb begin
    owner_next = owner_reg;
    last_next  = last_reg;
    wdog_next  = '0;
    case (owner_reg)
      OWN_NONE: begin
        if (m0_sel_in && m1_sel_in)
          owner_next = (FIXED_PRIORITY != 0 || last_reg) ? OWN_M0 : OWN_M1;
        else if (m0_sel_in)
          owner_next = OWN_M0;
        else if (m1_sel_in)
          owner_next = OWN_M1;
      end
      OWN_M0: begin
        // Completion always hands over to the other master if it waits.
        if (done) begin
          last_next  = 1'b0;
          owner_next = m1_sel_in ? OWN_M1 : OWN_NONE;
        end else if (!m0_sel_in) begin
          owner_next = OWN_NONE;
        end else begin
          wdog_next = wdog_reg + WDOG_W'(1);
        end
      end
      OWN_M1: begin
        if (done) begin
          last_next  = 1'b1;
          owner_next = m0_sel_in ? OWN_M0 : OWN_NONE;
        end else if (!m1_sel_in) begin
          owner_next = OWN_NONE;
        end else begin
          wdog_next = wdog_reg + WDOG_W'(1);
        end
      end
      default: owner_next = OWN_NONE;
    endcase
  end

  always_comb begin
    s_address_out     = '0;
    s_sel_out         = 1'b0;
    s_read_out        = 1'b0;
    s_write_mask_out  = '0;
    s_write_value_out = '0;
    m0_read_value_out = '0;
    m0_ready_out      = 1'b0;
    m1_read_value_out = '0;
    m1_ready_out      = 1'b0;
    timeout_out       = timeout_hit;
    if (grant0) begin
      s_address_out     = m0_address_in;
      s_sel_out         = m0_sel_in;
      s_read_out        = m0_read_in;
      s_write_mask_out  = m0_write_mask_in;
      s_write_value_out = m0_write_value_in;
      m0_read_value_out = timeout_hit ? '0 : s_read_value_in;
      m0_ready_out      = s_ready_in || timeout_hit;
    end else if (grant1) begin
      s_address_out     = m1_address_in;
      s_sel_out         = m1_sel_in;
      s_read_out        = m1_read_in;
      s_write_mask_out  = m1_write_mask_in;
      s_write_value_out = m1_write_value_in;
      m1_read_value_out = timeout_hit ? '0 : s_read_value_in;
      m1_ready_out      = s_ready_in || timeout_hit;
    end
  end

endmodule
